// File: rtl/fpu_shared_pkg.sv
// Shared constants and payload types for the shared-FPU dispatch path.
package fpu_shared_pkg;

  localparam int unsigned C_DATA_WIDTH = 32;
  localparam int unsigned C_OP_WIDTH   = 4;
  localparam int unsigned C_RM_WIDTH   = 2;
  localparam int unsigned C_TAG_WIDTH  = 7;
  localparam int unsigned C_FLAG_WIDTH = 9;

  // Bit positions inside the result flag word
  typedef enum int unsigned {
    FLAG_OF   = 0,
    FLAG_UF   = 1,
    FLAG_ZERO = 4,
    FLAG_IX   = 5,
    FLAG_IV   = 6,
    FLAG_INF  = 7
  } fpu_flag_e;

  typedef struct packed {
    logic [C_DATA_WIDTH-1:0] arga;
    logic [C_DATA_WIDTH-1:0] argb;
    logic [C_OP_WIDTH-1:0]   op;
    logic [C_RM_WIDTH-1:0]   rm;
  } fpu_req_t;

endpackage

// File: rtl/fpu_shared_rr_arb.sv
// Combinational round-robin picker: first eligible index at or after the pointer.
module fpu_shared_rr_arb #(
  parameter int unsigned N = 4,
  localparam int unsigned C_IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]       Elig_SI,
  input  logic [C_IDX_W-1:0] Ptr_DI,
  output logic [N-1:0]       Gnt_SO,
  output logic [C_IDX_W-1:0] Idx_DO,
  output logic               Valid_SO
);

  always_comb begin
    int unsigned j;
    Gnt_SO   = '0;
    Idx_DO   = '0;
    Valid_SO = 1'b0;
    j        = 0;
    for (int unsigned k = 0; k < N; k++) begin
      j = 32'(Ptr_DI) + k;
      if (j >= N) j = j - N;
      if (!Valid_SO && Elig_SI[C_IDX_W'(j)]) begin
        Valid_SO                 = 1'b1;
        Gnt_SO[C_IDX_W'(j)]      = 1'b1;
        Idx_DO                   = C_IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/fpu_shared_dispatch.sv
// Initiator side of the shared FPU: round-robin request dispatch with core tags,
// and tag-steered result capture into per-core holding registers.
module fpu_shared_dispatch
  import fpu_shared_pkg::*;
#(
  parameter int unsigned NUM_CORES       = 4,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                                     Clk_CI,
  input  logic                                     Rst_RI,
  input  logic [NUM_CORES-1:0]                     Core_Valid_SI,
  output logic [NUM_CORES-1:0]                     Core_Ready_SO,
  input  logic [NUM_CORES-1:0][C_DATA_WIDTH-1:0]   Core_OpA_DI,
  input  logic [NUM_CORES-1:0][C_DATA_WIDTH-1:0]   Core_OpB_DI,
  input  logic [NUM_CORES-1:0][C_OP_WIDTH-1:0]     Core_Op_SI,
  input  logic [NUM_CORES-1:0][C_RM_WIDTH-1:0]     Core_RM_SI,
  output logic [NUM_CORES-1:0]                     Core_ResValid_SO,
  input  logic [NUM_CORES-1:0]                     Core_ResReady_SI,
  output logic [NUM_CORES-1:0][C_DATA_WIDTH-1:0]   Core_Result_DO,
  output logic [NUM_CORES-1:0][C_FLAG_WIDTH-1:0]   Core_Flags_DO,
  output logic [C_DATA_WIDTH-1:0]                  Arga_DO,
  output logic [C_DATA_WIDTH-1:0]                  Argb_DO,
  output logic [C_OP_WIDTH-1:0]                    Op_SO,
  output logic [C_RM_WIDTH-1:0]                    RMFlags_SO,
  output logic                                     Valid_SO,
  output logic [C_TAG_WIDTH-1:0]                   Tag_DO,
  input  logic                                     Ready_SI,
  input  logic [C_DATA_WIDTH-1:0]                  Result_DI,
  input  logic [C_FLAG_WIDTH-1:0]                  Flags_DI,
  input  logic [C_TAG_WIDTH-1:0]                   TagUs_DI,
  input  logic                                     Req_SI,
  output logic                                     Ack_SO,
  output logic                                     TagErr_SO
);

  localparam int unsigned C_IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam int unsigned C_CNT_W = $clog2(MAX_OUTSTANDING + 1);

  logic [C_IDX_W-1:0]                ptr_q, ptr_nxt, win_idx, tag_idx;
  logic [NUM_CORES-1:0][C_CNT_W-1:0] outst_q;
  logic [NUM_CORES-1:0]              elig, gnt, cap, drain, inc, dec;
  logic [NUM_CORES-1:0]              resvalid_q;
  logic [NUM_CORES-1:0][C_DATA_WIDTH-1:0] result_q;
  logic [NUM_CORES-1:0][C_FLAG_WIDTH-1:0] flags_q;
  logic                              any_elig, accept, tag_ok, capture, tagerr_q;
  fpu_req_t                          req;

  always_comb begin
    elig = '0;
    for (int unsigned i = 0; i < NUM_CORES; i++)
      elig[i] = Core_Valid_SI[i] & (outst_q[i] != C_CNT_W'(MAX_OUTSTANDING));
  end

  fpu_shared_rr_arb #(.N(NUM_CORES)) i_arb (
    .Elig_SI  (elig),
    .Ptr_DI   (ptr_q),
    .Gnt_SO   (gnt),
    .Idx_DO   (win_idx),
    .Valid_SO (any_elig)
  );

  // Downstream payload mux; zeroed when nothing is eligible
  always_comb begin
    req = '0;
    if (any_elig) begin
      req.arga = Core_OpA_DI[win_idx];
      req.argb = Core_OpB_DI[win_idx];
      req.op   = Core_Op_SI[win_idx];
      req.rm   = Core_RM_SI[win_idx];
    end
  end

  assign Arga_DO       = req.arga;
  assign Argb_DO       = req.argb;
  assign Op_SO         = req.op;
  assign RMFlags_SO    = req.rm;
  assign Valid_SO      = any_elig;
  assign Tag_DO        = any_elig ? C_TAG_WIDTH'(win_idx) : '0;
  assign accept        = any_elig & Ready_SI;
  assign Core_Ready_SO = accept ? gnt : '0;
  assign ptr_nxt       = ((32'(win_idx) + 32'd1) >= NUM_CORES) ? '0
                                                               : C_IDX_W'(32'(win_idx) + 32'd1);

  // Upstream handshake: out-of-range tags are acked and dropped
  assign tag_ok  = 32'(TagUs_DI) < NUM_CORES;
  assign tag_idx = C_IDX_W'(TagUs_DI);

  always_comb begin
    Ack_SO = Req_SI;
    if (tag_ok) Ack_SO = Req_SI & (~resvalid_q[tag_idx] | Core_ResReady_SI[tag_idx]);
  end

  assign capture = Req_SI & Ack_SO & tag_ok;

  always_comb begin
    cap   = '0;
    drain = '0;
    inc   = '0;
    dec   = '0;
    for (int unsigned i = 0; i < NUM_CORES; i++) begin
      cap[i]   = capture & (32'(tag_idx) == i);
      drain[i] = resvalid_q[i] & Core_ResReady_SI[i];
      inc[i]   = accept & gnt[i];
      // A result can arrive for a core whose bookkeeping was reset; never go below zero
      dec[i]   = drain[i] & (outst_q[i] != '0);
    end
  end

  always_ff @(posedge Clk_CI) begin
    if (Rst_RI) begin
      ptr_q      <= '0;
      outst_q    <= '0;
      resvalid_q <= '0;
      result_q   <= '0;
      flags_q    <= '0;
      tagerr_q   <= 1'b0;
    end else begin
      if (accept) ptr_q <= ptr_nxt;
      tagerr_q <= Req_SI & ~tag_ok;
      for (int unsigned i = 0; i < NUM_CORES; i++) begin
        if (cap[i]) begin
          result_q[i]   <= Result_DI;
          flags_q[i]    <= Flags_DI;
          resvalid_q[i] <= 1'b1;
        end else if (drain[i]) begin
          resvalid_q[i] <= 1'b0;
        end
        if (inc[i] && !dec[i])      outst_q[i] <= outst_q[i] + C_CNT_W'(1);
        else if (dec[i] && !inc[i]) outst_q[i] <= outst_q[i] - C_CNT_W'(1);
      end
    end
  end

  assign Core_ResValid_SO = resvalid_q;
  assign Core_Result_DO   = result_q;
  assign Core_Flags_DO    = flags_q;
  assign TagErr_SO        = tagerr_q;

endmodule

// File: tb/tb_fpu_shared_dispatch.sv
// Scenario bench for fpu_shared_dispatch with grant and per-core result scoreboards.
module tb_fpu_shared_dispatch;

  localparam int unsigned NC = 4;

  logic clk = 1'b0;
  logic rst;
  logic [NC-1:0]        core_valid, core_ready, res_valid, res_ready;
  logic [NC-1:0][31:0]  opa, opb, core_result;
  logic [NC-1:0][3:0]   op;
  logic [NC-1:0][1:0]   rm;
  logic [NC-1:0][8:0]   core_flags;
  logic [31:0]          arga, argb, result;
  logic [3:0]           op_o;
  logic [1:0]           rm_o;
  logic [8:0]           flags;
  logic [6:0]           tag_o, tag_us;
  logic                 valid_o, ready, req, ack, tagerr;

  int n_checks = 0;
  int n_fail   = 0;
  int unsigned exp_gnt[$];
  logic [40:0] exp_res[NC][$];

  always #5 clk = ~clk;

  fpu_shared_dispatch #(.NUM_CORES(NC), .MAX_OUTSTANDING(4)) dut (
    .Clk_CI           (clk),
    .Rst_RI           (rst),
    .Core_Valid_SI    (core_valid),
    .Core_Ready_SO    (core_ready),
    .Core_OpA_DI      (opa),
    .Core_OpB_DI      (opb),
    .Core_Op_SI       (op),
    .Core_RM_SI       (rm),
    .Core_ResValid_SO (res_valid),
    .Core_ResReady_SI (res_ready),
    .Core_Result_DO   (core_result),
    .Core_Flags_DO    (core_flags),
    .Arga_DO          (arga),
    .Argb_DO          (argb),
    .Op_SO            (op_o),
    .RMFlags_SO       (rm_o),
    .Valid_SO         (valid_o),
    .Tag_DO           (tag_o),
    .Ready_SI         (ready),
    .Result_DI        (result),
    .Flags_DI         (flags),
    .TagUs_DI         (tag_us),
    .Req_SI           (req),
    .Ack_SO           (ack),
    .TagErr_SO        (tagerr)
  );

  task automatic drive_idle();
    core_valid = '0;
    res_ready  = '0;
    ready      = 1'b0;
    req        = 1'b0;
    tag_us     = '0;
    result     = '0;
    flags      = '0;
    for (int i = 0; i < NC; i++) begin
      opa[i] = 32'h1000_0000 | 32'(i);
      opb[i] = 32'h2000_0000 | 32'(i);
      op[i]  = 4'(i + 1);
      rm[i]  = 2'(i);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive_idle();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_gnt.delete();
    for (int i = 0; i < NC; i++) exp_res[i].delete();
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_checks++;
    if (valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", valid_o); end
    n_checks++;
    if (res_valid !== 4'b0) begin n_fail++; $display("FAIL reset_resvalid got %b want 0000", res_valid); end
    n_checks++;
    if (tagerr !== 1'b0) begin n_fail++; $display("FAIL reset_tagerr got %b want 0", tagerr); end
    n_checks++;
    if (core_result !== '0 || core_flags !== '0) begin
      n_fail++; $display("FAIL reset_holding got %h/%h want 0", core_result, core_flags);
    end
    n_checks++;
    if (tag_o !== 7'd0 || arga !== 32'd0 || op_o !== 4'd0) begin
      n_fail++; $display("FAIL reset_payload got tag %0d arga %h op %h want 0", tag_o, arga, op_o);
    end
  endtask

  task automatic test_two_core();
    int unsigned e;
    do_reset();
    exp_gnt.push_back(0);
    exp_gnt.push_back(2);
    core_valid = 4'b0101;
    ready      = 1'b1;
    for (int c = 0; c < 2; c++) begin
      #1;
      e = exp_gnt.pop_front();
      n_checks++;
      if (32'(tag_o) !== e || arga !== opa[e] || argb !== opb[e] || op_o !== op[e] ||
          rm_o !== rm[e] || core_ready !== 4'(1 << e)) begin
        n_fail++;
        $display("FAIL two_core_grant%0d got tag %0d arga %h ready %b want tag %0d arga %h", c, tag_o, arga,
                 core_ready, e, opa[e]);
      end
      @(negedge clk);
      core_valid = 4'b0100;
    end
    core_valid = 4'b1111;
    ready      = 1'b0;
    #1;
    n_checks++;
    if (valid_o !== 1'b1 || tag_o !== 7'd3) begin
      n_fail++; $display("FAIL rr_pointer got valid %b tag %0d want 1 tag 3", valid_o, tag_o);
    end
    n_checks++;
    if (core_ready !== 4'b0) begin n_fail++; $display("FAIL ready_gated got %b want 0000", core_ready); end
  endtask

  task automatic test_all_valid();
    int unsigned e;
    do_reset();
    for (int k = 0; k < 8; k++) exp_gnt.push_back(32'(k % 4));
    core_valid = 4'b1111;
    ready      = 1'b1;
    for (int c = 0; c < 8; c++) begin
      #1;
      if (valid_o && ready) begin
        e = exp_gnt.pop_front();
        n_checks++;
        if (32'(tag_o) !== e || arga !== opa[e] || core_ready !== 4'(1 << e)) begin
          n_fail++;
          $display("FAIL all_valid_grant%0d got tag %0d arga %h want tag %0d arga %h", c, tag_o, arga, e, opa[e]);
        end
      end
      @(negedge clk);
    end
    n_checks++;
    if (exp_gnt.size() != 0) begin n_fail++; $display("FAIL all_valid_count got %0d left want 0", exp_gnt.size()); end
  endtask

  task automatic test_outstanding();
    logic [40:0] e;
    do_reset();
    core_valid = 4'b0010;
    ready      = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      n_checks++;
      if (core_ready !== 4'b0010) begin n_fail++; $display("FAIL outst_accept%0d got %b want 0010", c, core_ready); end
      @(negedge clk);
    end
    #1;
    n_checks++;
    if (valid_o !== 1'b0 || core_ready !== 4'b0) begin
      n_fail++; $display("FAIL outst_full got valid %b ready %b want 0 0000", valid_o, core_ready);
    end
    req    = 1'b1;
    tag_us = 7'd1;
    result = 32'hCAFE_0001;
    flags  = 9'h021;
    exp_res[1].push_back({result, flags});
    #1;
    n_checks++;
    if (ack !== 1'b1) begin n_fail++; $display("FAIL outst_ack got %b want 1", ack); end
    @(negedge clk);
    req       = 1'b0;
    res_ready = 4'b0010;
    #1;
    n_checks++;
    if (res_valid !== 4'b0010 || valid_o !== 1'b0) begin
      n_fail++; $display("FAIL outst_capture got resvalid %b valid %b want 0010 0", res_valid, valid_o);
    end
    if (res_valid[1] && res_ready[1] && exp_res[1].size() > 0) begin
      e = exp_res[1].pop_front();
      n_checks++;
      if ({core_result[1], core_flags[1]} !== e) begin
        n_fail++; $display("FAIL outst_result got %h want %h", {core_result[1], core_flags[1]}, e);
      end
    end
    @(negedge clk);
    res_ready = '0;
    #1;
    n_checks++;
    if (valid_o !== 1'b1 || core_ready !== 4'b0010) begin
      n_fail++; $display("FAIL outst_reenable got valid %b ready %b want 1 0010", valid_o, core_ready);
    end
  endtask

  task automatic test_stall();
    logic [40:0] e;
    do_reset();
    req    = 1'b1;
    tag_us = 7'd3;
    result = 32'h4000_0000;
    flags  = 9'h010;
    exp_res[3].push_back({result, flags});
    #1;
    n_checks++;
    if (ack !== 1'b1) begin n_fail++; $display("FAIL stall_first_ack got %b want 1", ack); end
    @(negedge clk);
    result = 32'h3F80_0000;
    flags  = 9'h020;
    #1;
    n_checks++;
    if (res_valid[3] !== 1'b1 || ack !== 1'b0) begin
      n_fail++; $display("FAIL stall_ack got resvalid %b ack %b want 1 0", res_valid[3], ack);
    end
    @(negedge clk);
    #1;
    n_checks++;
    if (ack !== 1'b0 || core_result[3] !== 32'h4000_0000) begin
      n_fail++; $display("FAIL stall_hold got ack %b result %h want 0 40000000", ack, core_result[3]);
    end
    @(negedge clk);
    res_ready[3] = 1'b1;
    #1;
    n_checks++;
    if (ack !== 1'b1) begin n_fail++; $display("FAIL stall_release_ack got %b want 1", ack); end
    if (res_valid[3] && exp_res[3].size() > 0) begin
      e = exp_res[3].pop_front();
      n_checks++;
      if ({core_result[3], core_flags[3]} !== e) begin
        n_fail++; $display("FAIL stall_drain0 got %h want %h", {core_result[3], core_flags[3]}, e);
      end
    end
    exp_res[3].push_back({result, flags});
    @(negedge clk);
    req       = 1'b0;
    res_ready = '0;
    #1;
    n_checks++;
    if (res_valid[3] !== 1'b1 || core_result[3] !== 32'h3F80_0000) begin
      n_fail++; $display("FAIL stall_capture got valid %b result %h want 1 3f800000", res_valid[3], core_result[3]);
    end
    @(negedge clk);
    res_ready[3] = 1'b1;
    #1;
    if (res_valid[3] && exp_res[3].size() > 0) begin
      e = exp_res[3].pop_front();
      n_checks++;
      if ({core_result[3], core_flags[3]} !== e) begin
        n_fail++; $display("FAIL stall_drain1 got %h want %h", {core_result[3], core_flags[3]}, e);
      end
    end
    @(negedge clk);
    res_ready = '0;
    #1;
    n_checks++;
    if (res_valid !== 4'b0 || exp_res[3].size() != 0) begin
      n_fail++; $display("FAIL stall_drain_clear got %b left %0d want 0000 0", res_valid, exp_res[3].size());
    end
    core_valid = 4'b1000;
    #1;
    n_checks++;
    if (valid_o !== 1'b1 || tag_o !== 7'd3) begin
      n_fail++; $display("FAIL no_underflow got valid %b tag %0d want 1 3", valid_o, tag_o);
    end
  endtask

  task automatic test_bad_tag();
    do_reset();
    req    = 1'b1;
    tag_us = 7'h7F;
    result = 32'h0000_DEAD;
    #1;
    n_checks++;
    if (ack !== 1'b1 || tagerr !== 1'b0) begin
      n_fail++; $display("FAIL bad_tag_ack got ack %b err %b want 1 0", ack, tagerr);
    end
    @(negedge clk);
    req = 1'b0;
    #1;
    n_checks++;
    if (tagerr !== 1'b1 || res_valid !== 4'b0) begin
      n_fail++; $display("FAIL bad_tag_err got err %b resvalid %b want 1 0000", tagerr, res_valid);
    end
    @(negedge clk);
    req    = 1'b1;
    tag_us = 7'd4;
    #1;
    n_checks++;
    if (tagerr !== 1'b0 || ack !== 1'b1) begin
      n_fail++; $display("FAIL bad_tag_pulse got err %b ack %b want 0 1", tagerr, ack);
    end
    @(negedge clk);
    req = 1'b0;
    #1;
    n_checks++;
    if (tagerr !== 1'b1 || res_valid !== 4'b0) begin
      n_fail++; $display("FAIL bad_tag_edge got err %b resvalid %b want 1 0000", tagerr, res_valid);
    end
  endtask

  task automatic test_back_to_back();
    int unsigned tags[4] = '{0, 2, 2, 1};
    int drains = 0;
    logic [40:0] e;
    do_reset();
    res_ready = 4'b1111;
    for (int k = 0; k < 6; k++) begin
      req = (k < 4);
      if (k < 4) begin
        tag_us = 7'(tags[k]);
        result = 32'hA000_0000 | 32'(k);
        flags  = 9'(k + 1);
        exp_res[tags[k]].push_back({result, flags});
      end
      #1;
      for (int i = 0; i < NC; i++) begin
        if (res_valid[i] && res_ready[i]) begin
          drains++;
          n_checks++;
          if (exp_res[i].size() == 0) begin
            n_fail++; $display("FAIL b2b_extra core %0d got %h want none", i, core_result[i]);
          end else begin
            e = exp_res[i].pop_front();
            if ({core_result[i], core_flags[i]} !== e) begin
              n_fail++; $display("FAIL b2b_result core %0d got %h want %h", i, {core_result[i], core_flags[i]}, e);
            end
          end
        end
      end
      if (k < 4) begin
        n_checks++;
        if (ack !== 1'b1) begin n_fail++; $display("FAIL b2b_ack%0d got %b want 1", k, ack); end
      end
      @(negedge clk);
    end
    n_checks++;
    if (drains != 4) begin n_fail++; $display("FAIL b2b_drains got %0d want 4", drains); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    core_valid = 4'b0001;
    ready      = 1'b1;
    for (int c = 0; c < 2; c++) begin
      req    = (c == 1);
      tag_us = 7'd0;
      result = 32'h1234_5678;
      @(negedge clk);
    end
    drive_idle();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++;
    if (res_valid !== 4'b0 || core_result[0] !== 32'd0) begin
      n_fail++; $display("FAIL mid_reset_hold got valid %b result %h want 0000 0", res_valid, core_result[0]);
    end
    core_valid = 4'b1111;
    #1;
    n_checks++;
    if (valid_o !== 1'b1 || tag_o !== 7'd0) begin
      n_fail++; $display("FAIL mid_reset_ptr got valid %b tag %0d want 1 0", valid_o, tag_o);
    end
    core_valid = 4'b0001;
    ready      = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      n_checks++;
      if (core_ready !== 4'b0001) begin n_fail++; $display("FAIL mid_reset_cnt%0d got %b want 0001", c, core_ready); end
      @(negedge clk);
    end
    #1;
    n_checks++;
    if (valid_o !== 1'b0) begin n_fail++; $display("FAIL mid_reset_full got %b want 0", valid_o); end
  endtask

  initial begin
    rst = 1'b1;
    drive_idle();
    test_reset();
    test_two_core();
    test_all_valid();
    test_outstanding();
    test_stall();
    test_bad_tag();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
